// File: rtl/alu_byte_sequencer_if.sv
// Bus bundle for alu_byte_sequencer: CPU-side request/result handshake and the shared 8-bit ALU port.
// Handshake: a request transfers on a rising edge where start_i=1 and ready_o=1; done_o pulses once per accepted request.
interface alu_byte_sequencer_if #(
    parameter int NBYTES = 2
);
    localparam int W = 8 * NBYTES;

    logic           start_i;
    logic           ready_o;
    logic [1:0]     op_i;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           cin_i;
    logic           done_o;
    logic [W-1:0]   result_o;
    logic [2:0]     czn_o;
    logic [7:0]     alu_a_o;
    logic [7:0]     alu_b_o;
    logic [1:0]     alu_op_o;
    logic           alu_c_o;
    logic [7:0]     alu_result_i;
    logic [2:0]     alu_czn_i;
    logic [1:0]     state_dbg;

    modport slave (
        input  start_i, op_i, a_i, b_i, cin_i, alu_result_i, alu_czn_i,
        output ready_o, done_o, result_o, czn_o,
        output alu_a_o, alu_b_o, alu_op_o, alu_c_o, state_dbg
    );

    modport master (
        output start_i, op_i, a_i, b_i, cin_i, alu_result_i, alu_czn_i,
        input  ready_o, done_o, result_o, czn_o,
        input  alu_a_o, alu_b_o, alu_op_o, alu_c_o, state_dbg
    );
endinterface

// File: rtl/alu_byte_sequencer.sv
// Runs 8*NBYTES-bit ADD/AND/OR on a shared 8-bit ALU, one byte per cycle, LSB first, and builds C/Z/N.
// Optional feature: define ALU_SEQ_SUB_EN to make op 11 a subtract (a - b); otherwise op 11 behaves as ADD.
module alu_byte_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_byte_sequencer_if.slave   bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

`ifdef ALU_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, work_q, result_q;
    logic [1:0]      op_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q, zero_q;
    logic [2:0]      czn_q;
    logic            is_add_q, is_sub_q, accept;

    // Op 11 is an add in both builds; with subtract enabled it also inverts b and forces carry-in.
    assign is_add_q = (op_q == 2'b00) || (op_q == 2'b11);
    assign is_sub_q = SUB_EN && (op_q == 2'b11);
    assign accept   = (state_q == IDLE) && bus.start_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.ready_o  = 1'b0;
        bus.done_o   = 1'b0;
        bus.alu_a_o  = 8'h00;
        bus.alu_b_o  = 8'h00;
        bus.alu_op_o = 2'b00;
        bus.alu_c_o  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                bus.alu_a_o  = a_q[8*int'(idx_q) +: 8];
                bus.alu_b_o  = is_sub_q ? ~b_q[8*int'(idx_q) +: 8] : b_q[8*int'(idx_q) +: 8];
                bus.alu_op_o = is_add_q ? 2'b00 : op_q;
                bus.alu_c_o  = is_add_q ? carry_q : 1'b0;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            work_q   <= '0;
            result_q <= '0;
            czn_q    <= 3'b000;
        end else begin
            if (accept) begin
                a_q    <= bus.a_i;
                b_q    <= bus.b_i;
                op_q   <= bus.op_i;
                idx_q  <= '0;
                zero_q <= 1'b1;
                if (SUB_EN && bus.op_i == 2'b11)
                    carry_q <= 1'b1;
                else if (bus.op_i == 2'b00 || bus.op_i == 2'b11)
                    carry_q <= bus.cin_i;
                else
                    carry_q <= 1'b0;
            end
            if (state_q == RUN) begin
                work_q[8*int'(idx_q) +: 8] <= bus.alu_result_i;
                carry_q <= is_add_q ? bus.alu_czn_i[2] : 1'b0;
                zero_q  <= zero_q & (bus.alu_result_i == 8'h00);
                if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
            end
            // N comes from the assembled word, not from the ALU's per-byte flag.
            if (state_q == DONE) begin
                result_q <= work_q;
                czn_q    <= {carry_q, zero_q, work_q[W-1]};
            end
        end
    end

    assign bus.result_o  = result_q;
    assign bus.czn_o     = czn_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer (NBYTES=2) with a behavioural 8-bit ALU on the ALU port.
module tb_alu_byte_sequencer;
    localparam int NBYTES = 2;
    localparam int W = 8 * NBYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    logic [W+2:0] exp_q[$];

    alu_byte_sequencer_if #(.NBYTES(NBYTES)) bus ();

    alu_byte_sequencer #(.NBYTES(NBYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference 8-bit ALU: 00 add with carry, 01 and, 10 or.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o} + {8'h00, bus.alu_c_o};
        case (bus.alu_op_o)
            2'b00:   bus.alu_result_i = alu_sum[7:0];
            2'b01:   bus.alu_result_i = bus.alu_a_o & bus.alu_b_o;
            2'b10:   bus.alu_result_i = bus.alu_a_o | bus.alu_b_o;
            default: bus.alu_result_i = 8'h00;
        endcase
        bus.alu_czn_i = {(bus.alu_op_o == 2'b00) ? alu_sum[8] : 1'b0,
                         bus.alu_result_i == 8'h00, bus.alu_result_i[7]};
    end

    always @(negedge clk) if (bus.done_o) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) check({tag, "_ready_timeout"}, 32'(bus.ready_o), 32'd1);
    endtask

    // Issue one op from a negedge, check ALU drive and latency, then result/flags once registered.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_res, input logic [2:0] exp_czn);
        int lat;
        logic [W+2:0] e;
        logic [7:0] exp_b0;
        logic exp_c0;
        logic [1:0] exp_aop;
        wait_ready(tag);
        bus.start_i = 1'b1;
        bus.op_i = op;
        bus.a_i = a;
        bus.b_i = b;
        bus.cin_i = cin;
        exp_q.push_back({exp_czn, exp_res});
        exp_b0 = b[7:0];
        exp_aop = (op == 2'b11) ? 2'b00 : op;
        exp_c0 = (op == 2'b00 || op == 2'b11) ? cin : 1'b0;
`ifdef ALU_SEQ_SUB_EN
        if (op == 2'b11) begin
            exp_b0 = ~b[7:0];
            exp_c0 = 1'b1;
        end
`endif
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 1;
        check({tag, "_run_ready"}, 32'(bus.ready_o), 32'd0);
        check({tag, "_alu_a0"}, 32'(bus.alu_a_o), 32'(a[7:0]));
        check({tag, "_alu_b0"}, 32'(bus.alu_b_o), 32'(exp_b0));
        check({tag, "_alu_op"}, 32'(bus.alu_op_o), 32'(exp_aop));
        check({tag, "_alu_c0"}, 32'(bus.alu_c_o), 32'(exp_c0));
        while (!bus.done_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NBYTES + 1));
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_result"}, 32'(bus.result_o), 32'(e[W-1:0]));
        check({tag, "_czn"}, 32'(bus.czn_o), 32'(e[W+2:W]));
    endtask

    initial begin
        int d0;
        bus.start_i = 1'b0;
        bus.op_i = 2'b00;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.cin_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", 32'(bus.result_o), 32'd0);
        check("rst_czn", 32'(bus.czn_o), 32'd0);
        check("rst_alu", {bus.alu_a_o, bus.alu_b_o, 13'd0, bus.alu_op_o, bus.alu_c_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("add_carry", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 3'b000);
        do_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 3'b110);
        do_op("add_cin", 2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0003, 3'b000);
        do_op("add_msb", 2'b00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 3'b110);
        do_op("and", 2'b01, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 3'b000);
        do_op("and_cin", 2'b01, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 3'b001);
        do_op("and_zero", 2'b01, 16'h1234, 16'h0000, 1'b0, 16'h0000, 3'b010);
        do_op("or", 2'b10, 16'h8000, 16'h0001, 1'b0, 16'h8001, 3'b001);
`ifdef ALU_SEQ_SUB_EN
        do_op("op11_sub", 2'b11, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 3'b001);
        do_op("op11_sub_eq", 2'b11, 16'h1234, 16'h1234, 1'b0, 16'h0000, 3'b110);
`else
        do_op("op11_add", 2'b11, 16'h0005, 16'h0007, 1'b0, 16'h000C, 3'b000);
        do_op("op11_add_cin", 2'b11, 16'h0005, 16'h0007, 1'b1, 16'h000D, 3'b000);
`endif

        // start_i held high: back-to-back accepts every NBYTES+2 cycles, ready only in IDLE.
        wait_ready("held");
        d0 = done_cnt;
        bus.start_i = 1'b1;
        bus.op_i = 2'b00;
        bus.a_i = 16'h0102;
        bus.b_i = 16'h0304;
        bus.cin_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("held_ready_%0d", k), 32'(bus.ready_o), 32'((k % 4) == 0));
            check($sformatf("held_done_%0d", k), 32'(bus.done_o), 32'((k % 4) == 3));
        end
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("held_done_count", 32'(done_cnt - d0), 32'd2);
        check("held_result", 32'(bus.result_o), 32'h0406);
        check("held_ready_end", 32'(bus.ready_o), 32'd1);

        // Reset mid-op: no done, registered outputs cleared.
        d0 = done_cnt;
        bus.start_i = 1'b1;
        bus.a_i = 16'h1111;
        bus.b_i = 16'h2222;
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_run_result", 32'(bus.result_o), 32'd0);
        check("rst_run_czn", 32'(bus.czn_o), 32'd0);
        check("rst_run_ready", 32'(bus.ready_o), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_run_no_done", 32'(done_cnt - d0), 32'd0);

        do_op("after_rst", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
